uart_tx_buffer: RTL and testbench
=================================

# uart_tx_buffer

Transmit-side byte buffer that sits directly upstream of the UART serializer (`UartTx`). The processor's console/MMIO path pushes bytes at full core speed. The block stores them in a small FIFO and feeds them one at a time to the serializer over its `WE`/`DATA`/`READY` handshake. It can optionally expand LF into CR LF. It also flags dropped bytes so software can detect console overrun.

## Interface
- `DEPTH_LOG`, default 4: FIFO depth is 2^DEPTH_LOG entries (16 by default); legal range 2..8.
- `CLK`  in  1: core clock, the same clock that drives `UartTx`.
- `RST_X`  in  1: reset; one clock; reset is asynchronous and active-low.
- `WR_EN`  in  1: push strobe from the CPU side; one byte per cycle when high.
- `WR_DATA`  in  8: byte to push.
- `CRLF_EN`  in  1: when high, a popped 0x0A is sent as 0x0D followed by 0x0A.
- `CLR_OVR`  in  1: synchronous clear of `OVERRUN`.
- `TX_READY`  in  1: `READY` output of `UartTx`.
- `TX_WE`  out  1: `WE` input of `UartTx`; single-cycle pulse, registered.
- `TX_DATA`  out  8: `DATA` input of `UartTx`; registered.
- `COUNT`  out  DEPTH_LOG+1: number of stored bytes, 0..2^DEPTH_LOG.
- `FULL`  out  1: `COUNT == 2^DEPTH_LOG`.
- `EMPTY`  out  1: `COUNT == 0`.
- `OVERRUN`  out  1: sticky; set when a push is dropped.

## Operation
- Storage: circular buffer with DEPTH_LOG-bit read and write pointers. Both pointers wrap modulo the depth. `COUNT` is held as a separate register. `FULL`, `EMPTY` and `COUNT` are registered and reflect the state after the most recent edge.
- Push: accepted when `WR_EN` is high and `COUNT` (the pre-edge value) is below the depth. An accepted push writes `WR_DATA` at the write pointer and increments the write pointer.
- Dropped push: `WR_EN` while `FULL` does not write. It sets `OVERRUN`. A pop in the same cycle does not rescue the push; the decision uses the pre-edge `COUNT`.
- Pop and push in the same cycle: `COUNT` is unchanged and both pointers advance.
- `OVERRUN` clear: `CLR_OVR` clears it. If a drop and `CLR_OVR` occur in the same cycle, the set wins.
- Sender FSM states: IDLE, PULSE, WAIT.
  - IDLE to PULSE requires `TX_READY==1` and either (a) a pending LF or (b) a non-empty FIFO.
    - Pending LF: `TX_DATA` is loaded with 0x0A and the pending flag is cleared. No pop occurs.
    - Non-empty FIFO: the head byte B is popped.
      - If `CRLF_EN` is high and B is 0x0A, `TX_DATA` is loaded with 0x0D and the pending flag is set.
      - Otherwise `TX_DATA` is loaded with B.
    - `TX_WE` is loaded with 1.
  - PULSE to WAIT is unconditional. `TX_WE` is loaded with 0. `UartTx` captures `TX_DATA` at this edge and lowers `READY`.
  - WAIT to IDLE occurs when `TX_READY==1`, i.e. the serializer has finished the frame.
- The pending-LF flag has priority over the FIFO head. `CRLF_EN` is sampled only at the pop; toggling it while the flag is set does not cancel the following 0x0A.
- Reset values: `TX_WE`=0, `TX_DATA`=0x00, `COUNT`=0, `EMPTY`=1, `FULL`=0, `OVERRUN`=0, state=IDLE, pointers=0, pending flag=0. Reset mid-frame discards all buffered bytes and any pending LF; a `UartTx` frame already in flight is not tracked.

## Timing
- Latency, empty FIFO with `TX_READY` high: push at edge E; `TX_WE` is high during the cycle after edge E+1, so `UartTx` latches the byte at edge E+2.
- Back-to-back bytes: the next `TX_WE` rises 2 cycles after `TX_READY` returns high. It is never asserted while `TX_READY` is low.
- `TX_WE` is never high for 2 consecutive cycles.
- `TX_DATA` changes only on the IDLE to PULSE edge. It is stable during PULSE and WAIT.
- Throughput is bounded by `UartTx`: one byte per 10·`SERIAL_WCNT` cycles plus the handshake overhead.
- `COUNT` decrements at the IDLE to PULSE edge, not at frame completion.

## Test plan
- Reset: assert `RST_X` low asynchronously mid-cycle -> all outputs take their reset values immediately; after release, with no pushes, `TX_WE` stays 0 for 1000 cycles.
- Single byte: push 0x41 into an empty buffer with a `UartTx` model at `SERIAL_WCNT`=10 -> exactly one `TX_WE` pulse with `TX_DATA`=0x41 at E+2; the TXD waveform decodes to 0x41; `COUNT` returns to 0.
- Ordering: burst-push 0x00..0x0F in 16 consecutive cycles (default depth) -> `FULL`=1 after the 16th push; serial output is 0x00..0x0F in order; no `TX_WE` occurs while `TX_READY`=0.
- Overrun: fill to 16 entries, then push 0xAA while a pop happens in the same cycle -> 0xAA is not transmitted and `OVERRUN`=1; `CLR_OVR` clears it; drop and `CLR_OVR` together -> `OVERRUN` remains 1.
- CRLF: with `CRLF_EN`=1, push 0x48, 0x0A, 0x49 -> transmitted sequence is 0x48, 0x0D, 0x0A, 0x49; with `CRLF_EN`=0 the same pushes produce 0x48, 0x0A, 0x49.
- Wrap-around: with `DEPTH_LOG`=2, interleave 10 pushes and pops so the pointers wrap at least twice -> all bytes are delivered in order and `COUNT` never exceeds 4.

Source files
------------

// File: rtl/uart_tx_buffer_if.sv
// uart_tx_buffer_if
//   Groups the byte-push strobe from the CPU side and the WE/DATA/READY
//   handshake towards the UART serializer.
//   Signals:
//     WR_EN    push strobe, one byte per cycle when high
//     WR_DATA  byte to push
//     TX_READY READY from the serializer (high = idle, can accept a byte)
//     TX_WE    single-cycle write strobe into the serializer
//     TX_DATA  byte presented to the serializer
//   Modports:
//     slave  - the buffer itself
//     master - whatever drives pushes and models/hosts the serializer
interface uart_tx_buffer_if;
    logic       WR_EN;
    logic [7:0] WR_DATA;
    logic       TX_READY;
    logic       TX_WE;
    logic [7:0] TX_DATA;

    modport slave (
        input  WR_EN,
        input  WR_DATA,
        input  TX_READY,
        output TX_WE,
        output TX_DATA
    );

    modport master (
        output WR_EN,
        output WR_DATA,
        output TX_READY,
        input  TX_WE,
        input  TX_DATA
    );
endinterface

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer
//   Transmit byte FIFO in front of the UART serializer. Bytes pushed at core
//   speed are stored in a 2^DEPTH_LOG entry circular buffer and handed to the
//   serializer one at a time over WE/DATA/READY. Optionally expands LF into
//   CR LF, and flags dropped pushes with a sticky OVERRUN bit.
//   Ports:
//     CLK      core clock (same clock as the serializer)
//     RST_X    asynchronous active-low reset
//     CRLF_EN  when high, a popped 0x0A goes out as 0x0D then 0x0A
//     CLR_OVR  synchronous clear of OVERRUN (a simultaneous drop wins)
//     bus      push strobe/data and serializer handshake (slave side)
//     COUNT    number of stored bytes, 0..2^DEPTH_LOG (registered)
//     FULL     COUNT == 2^DEPTH_LOG (registered)
//     EMPTY    COUNT == 0 (registered)
//     OVERRUN  sticky, set when a push is dropped
module uart_tx_buffer #(
    parameter int DEPTH_LOG = 4
) (
    input  logic                 CLK,
    input  logic                 RST_X,
    input  logic                 CRLF_EN,
    input  logic                 CLR_OVR,
    uart_tx_buffer_if.slave      bus,
    output logic [DEPTH_LOG:0]   COUNT,
    output logic                 FULL,
    output logic                 EMPTY,
    output logic                 OVERRUN
);

    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] DEPTH_C = {1'b1, {DEPTH_LOG{1'b0}}};
    localparam logic [7:0] CHR_LF = 8'h0A;
    localparam logic [7:0] CHR_CR = 8'h0D;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t               state, state_n;
    logic [7:0]           mem [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr, rd_ptr;
    logic                 pend, pend_n;      // LF still owed after a CR
    logic                 tx_we_n;
    logic [7:0]           tx_data_n;
    logic                 pop;
    logic                 push_ok;
    logic                 drop;
    logic [DEPTH_LOG:0]   count_n;
    logic [7:0]           head;

    assign head = mem[rd_ptr];

    // The accept/drop decision uses the registered FULL flag, so a pop in
    // the same cycle never makes room for a push that arrives while full.
    assign push_ok = bus.WR_EN && !FULL;
    assign drop    = bus.WR_EN &&  FULL;

    // Sender FSM: next state, registered-output next values, pop strobe.
    always_comb begin
        state_n   = state;
        pend_n    = pend;
        tx_we_n   = 1'b0;
        tx_data_n = bus.TX_DATA;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.TX_READY) begin
                    if (pend) begin
                        // Owed LF has priority over the FIFO head.
                        tx_data_n = CHR_LF;
                        pend_n    = 1'b0;
                        tx_we_n   = 1'b1;
                        state_n   = S_PULSE;
                    end else if (!EMPTY) begin
                        pop     = 1'b1;
                        tx_we_n = 1'b1;
                        state_n = S_PULSE;
                        // CRLF_EN is only looked at here, at the pop.
                        if (CRLF_EN && head == CHR_LF) begin
                            tx_data_n = CHR_CR;
                            pend_n    = 1'b1;
                        end else begin
                            tx_data_n = head;
                        end
                    end
                end
            end
            // Serializer latches DATA on this edge and drops READY.
            S_PULSE: state_n = S_WAIT;
            S_WAIT: begin
                if (bus.TX_READY) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        count_n = COUNT;
        case ({push_ok, pop})
            2'b10:   count_n = COUNT + 1'b1;
            2'b01:   count_n = COUNT - 1'b1;
            default: count_n = COUNT;
        endcase
    end

    // Storage array has no reset; stale contents are never read because
    // pops are gated by EMPTY.
    always_ff @(posedge CLK) begin
        if (push_ok) mem[wr_ptr] <= bus.WR_DATA;
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state       <= S_IDLE;
            pend        <= 1'b0;
            bus.TX_WE   <= 1'b0;
            bus.TX_DATA <= 8'h00;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            COUNT       <= '0;
            FULL        <= 1'b0;
            EMPTY       <= 1'b1;
            OVERRUN     <= 1'b0;
        end else begin
            state       <= state_n;
            pend        <= pend_n;
            bus.TX_WE   <= tx_we_n;
            bus.TX_DATA <= tx_data_n;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            COUNT       <= count_n;
            FULL        <= (count_n == DEPTH_C);
            EMPTY       <= (count_n == '0);
            // Set beats clear when both happen in one cycle.
            if (drop)         OVERRUN <= 1'b1;
            else if (CLR_OVR) OVERRUN <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffer.sv
module tb_uart_tx_buffer;
    localparam int WCNT = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic crlf_en = 1'b0;
    logic clr_ovr = 1'b0;
    logic hold    = 1'b0;   // forces the serializer READY low
    logic ready2  = 1'b0;

    logic [4:0] count1;
    logic       full1, empty1, ovr1;
    logic [2:0] count2;
    logic       full2, empty2, ovr2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx_buffer_if if1();
    uart_tx_buffer_if if2();

    uart_tx_buffer #(.DEPTH_LOG(4)) dut1 (
        .CLK(clk), .RST_X(rst_n), .CRLF_EN(crlf_en), .CLR_OVR(clr_ovr),
        .bus(if1.slave), .COUNT(count1), .FULL(full1), .EMPTY(empty1), .OVERRUN(ovr1)
    );

    uart_tx_buffer #(.DEPTH_LOG(2)) dut2 (
        .CLK(clk), .RST_X(rst_n), .CRLF_EN(1'b0), .CLR_OVR(1'b0),
        .bus(if2.slave), .COUNT(count2), .FULL(full2), .EMPTY(empty2), .OVERRUN(ovr2)
    );

    // Serializer model for dut1: 1 start, 8 data LSB first, 1 stop, WCNT cycles/bit.
    logic       m_rdy;
    logic       txd;
    logic [8:0] m_sh;
    int         m_bits, m_cnt;
    logic [7:0] cap[$];
    logic [7:0] rx[$];
    logic [7:0] cap2[$];

    assign if1.TX_READY = m_rdy & ~hold;
    assign if2.TX_READY = ready2;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rdy  <= 1'b1;
            txd    <= 1'b1;
            m_sh   <= '0;
            m_bits <= 0;
            m_cnt  <= 0;
        end else if (if1.TX_WE && if1.TX_READY) begin
            cap.push_back(if1.TX_DATA);
            m_rdy  <= 1'b0;
            txd    <= 1'b0;
            m_sh   <= {1'b1, if1.TX_DATA};
            m_bits <= 9;
            m_cnt  <= WCNT - 1;
        end else if (!m_rdy) begin
            if (m_cnt == 0) begin
                if (m_bits == 0) begin
                    m_rdy <= 1'b1;
                end else begin
                    txd    <= m_sh[0];
                    m_sh   <= m_sh >> 1;
                    m_bits <= m_bits - 1;
                    m_cnt  <= WCNT - 1;
                end
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    // Serial line decoder, samples mid-bit.
    initial begin
        logic [7:0] rb;
        forever begin
            @(negedge txd);
            repeat (15) @(posedge clk);
            for (int b = 0; b < 8; b++) begin
                rb[b] = txd;
                if (b < 7) repeat (WCNT) @(posedge clk);
            end
            rx.push_back(rb);
            repeat (WCNT) @(posedge clk);
        end
    end

    // Protocol monitors.
    int   viol_rdy1 = 0, viol_b2b1 = 0, viol_b2b2 = 0, we_cnt1 = 0;
    logic we_prev1 = 1'b0, we_prev2 = 1'b0;
    logic [2:0] max2 = '0;

    always @(posedge clk) begin
        if (rst_n) begin
            if (if1.TX_WE && !if1.TX_READY) viol_rdy1 <= viol_rdy1 + 1;
            if (if1.TX_WE && we_prev1)      viol_b2b1 <= viol_b2b1 + 1;
            if (if2.TX_WE && we_prev2)      viol_b2b2 <= viol_b2b2 + 1;
            if (if1.TX_WE)                  we_cnt1   <= we_cnt1 + 1;
            if (if2.TX_WE)                  cap2.push_back(if2.TX_DATA);
            if (count2 > max2)              max2      <= count2;
        end
        we_prev1 <= if1.TX_WE;
        we_prev2 <= if2.TX_WE;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [7:0] d);
        if1.WR_EN   = 1'b1;
        if1.WR_DATA = d;
        tick();
        if1.WR_EN   = 1'b0;
    endtask

    task automatic wait_rx(input string tag, input int n, input int bound);
        int k = 0;
        while (rx.size() < n && k < bound) begin
            tick();
            k++;
        end
        chk(tag, rx.size(), n);
        repeat (20) tick();
    endtask

    initial begin
        int base;
        if1.WR_EN = 1'b0; if1.WR_DATA = 8'h00;
        if2.WR_EN = 1'b0; if2.WR_DATA = 8'h00;

        // Power-up reset
        #1 rst_n = 1'b0;
        #1;
        chk("rst0_count", count1, 0);
        chk("rst0_empty", empty1, 1);
        chk("rst0_full",  full1,  0);
        chk("rst0_ovr",   ovr1,   0);
        chk("rst0_we",    if1.TX_WE, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Reset asserted mid-cycle while a pulse is in progress
        if1.WR_EN = 1'b1; if1.WR_DATA = 8'h41;
        tick();
        if1.WR_DATA = 8'h42;
        tick();
        if1.WR_EN = 1'b0;
        chk("pre_rst_we",    if1.TX_WE,   1);
        chk("pre_rst_data",  if1.TX_DATA, 8'h41);
        chk("pre_rst_count", count1,      1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_we",    if1.TX_WE,   0);
        chk("rst_data",  if1.TX_DATA, 8'h00);
        chk("rst_count", count1,      0);
        chk("rst_empty", empty1,      1);
        repeat (2) tick();
        rst_n = 1'b1;
        base = we_cnt1;
        repeat (1000) tick();
        chk("idle_we_count", we_cnt1 - base, 0);
        chk("idle_cap", cap.size(), 0);

        // Single byte latency and decode
        cap.delete(); rx.delete();
        if1.WR_EN = 1'b1; if1.WR_DATA = 8'h41;
        tick();                                   // edge E
        if1.WR_EN = 1'b0;
        chk("single_count_E", count1, 1);
        chk("single_we_E",    if1.TX_WE, 0);
        tick();                                   // edge E+1
        chk("single_we_E1",   if1.TX_WE, 1);
        chk("single_data_E1", if1.TX_DATA, 8'h41);
        chk("single_count_E1", count1, 0);
        tick();                                   // edge E+2
        chk("single_we_E2",   if1.TX_WE, 0);
        chk("single_latched", m_rdy, 0);
        wait_rx("single_rx_n", 1, 400);
        chk("single_rx",  rx[0], 8'h41);
        chk("single_cap_n", cap.size(), 1);
        chk("single_count_end", count1, 0);

        // Ordered burst of 16
        rx.delete();
        hold = 1'b1;
        for (int i = 0; i < 16; i++) push1(8'(i));
        chk("burst_full",  full1,  1);
        chk("burst_count", count1, 16);
        hold = 1'b0;
        wait_rx("burst_rx_n", 16, 3000);
        for (int i = 0; i < 16; i++) chk($sformatf("burst_rx%0d", i), rx[i], i);
        chk("burst_empty", empty1, 1);

        // Drop while popping in the same cycle
        rx.delete();
        hold = 1'b1;
        for (int i = 0; i < 16; i++) push1(8'(8'h10 + i));
        chk("ovr_full", full1, 1);
        hold = 1'b0;
        push1(8'hAA);
        chk("ovr_count", count1, 15);
        chk("ovr_set",   ovr1,   1);
        chk("ovr_we",    if1.TX_WE, 1);
        chk("ovr_data",  if1.TX_DATA, 8'h10);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        chk("ovr_clr", ovr1, 0);
        wait_rx("ovr_rx_n", 16, 3000);
        for (int i = 0; i < 16; i++) chk($sformatf("ovr_rx%0d", i), rx[i], 8'h10 + i);

        // Drop and clear together: set wins
        rx.delete();
        hold = 1'b1;
        for (int i = 0; i < 16; i++) push1(8'(8'h20 + i));
        if1.WR_EN = 1'b1; if1.WR_DATA = 8'hBB; clr_ovr = 1'b1;
        tick();
        if1.WR_EN = 1'b0; clr_ovr = 1'b0;
        chk("ovr2_set",   ovr1,   1);
        chk("ovr2_count", count1, 16);
        hold = 1'b0;
        wait_rx("ovr2_rx_n", 16, 3000);
        chk("ovr2_last", rx[15], 8'h2F);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;

        // LF expansion on
        rx.delete();
        crlf_en = 1'b1;
        push1(8'h48); push1(8'h0A); push1(8'h49);
        wait_rx("crlf_rx_n", 4, 1200);
        chk("crlf_rx0", rx[0], 8'h48);
        chk("crlf_rx1", rx[1], 8'h0D);
        chk("crlf_rx2", rx[2], 8'h0A);
        chk("crlf_rx3", rx[3], 8'h49);

        // LF expansion off
        rx.delete();
        crlf_en = 1'b0;
        push1(8'h48); push1(8'h0A); push1(8'h49);
        wait_rx("lf_rx_n", 3, 1000);
        chk("lf_rx0", rx[0], 8'h48);
        chk("lf_rx1", rx[1], 8'h0A);
        chk("lf_rx2", rx[2], 8'h49);
        chk("lf_rx_size", rx.size(), 3);

        // Pointer wrap on a 4-deep instance
        for (int i = 0; i < 4; i++) begin
            if2.WR_EN = 1'b1; if2.WR_DATA = 8'(8'h50 + i);
            tick();
        end
        if2.WR_EN = 1'b0;
        chk("wrap_full",  full2,  1);
        chk("wrap_count", count2, 4);
        ready2 = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            if2.WR_EN = 1'b1; if2.WR_DATA = 8'(8'h54 + i);
            tick();
            if2.WR_EN = 1'b0;
            repeat (2) tick();
        end
        begin
            int k = 0;
            while (cap2.size() < 10 && k < 200) begin tick(); k++; end
        end
        repeat (5) tick();
        chk("wrap_n", cap2.size(), 10);
        for (int i = 0; i < 10; i++) chk($sformatf("wrap_tx%0d", i), cap2[i], 8'h50 + i);
        chk("wrap_max",   max2,   4);
        chk("wrap_ovr",   ovr2,   0);
        chk("wrap_empty", empty2, 1);

        // Handshake rules held throughout
        chk("we_while_busy", viol_rdy1, 0);
        chk("we_b2b_1",      viol_b2b1, 0);
        chk("we_b2b_2",      viol_b2b2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
